// File: rtl/pc_src_unit_pkg.sv
// Shared branch-decode constants for the next-PC select logic.
// Used by pc_src_unit and branch_cond.
package pc_src_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 lives in instr[14:12] for every B-type instruction
  function automatic logic [2:0] get_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

endpackage

// File: rtl/pc_src_unit_branch_cond.sv
// B-type condition evaluation: maps funct3 plus ALU flags to a taken
// decision, flagging the two funct3 codes that are not valid branches.
module branch_cond
  import pc_src_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       cond_true,
  output logic       bad_funct3
);

  // Condition lookup; 010/011 never take and are reported as illegal
  always_comb begin
    cond_true  = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_BEQ:  cond_true = zero;
      F3_BNE:  cond_true = ~zero;
      F3_BLT:  cond_true = lt;
      F3_BGE:  cond_true = ~lt;
      F3_BLTU: cond_true = ltu;
      F3_BGEU: cond_true = ~ltu;
      default: begin
        cond_true  = 1'b0;
        bad_funct3 = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_src_unit.sv
// Next-PC select for the unpipelined RV32I core, with registered status.
// Define PC_SRC_PERF_EN to add the taken/executed branch counters.
module pc_src_unit
  import pc_src_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch,
  input  logic             jump,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic [31:0]      instr,
  output logic             pc_src,
  output logic             bad_funct3,
  output logic             pc_src_q,
`ifdef PC_SRC_PERF_EN
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] branch_cnt,
`endif
  output logic             err_sticky
);

  logic w_cond_true;
  logic w_cond_bad;
  logic w_unused_instr;
  logic r_pc_src_q;
  logic r_err_sticky;

  assign w_unused_instr = ^{instr[31:15], instr[11:0]};

  branch_cond u_branch_cond (
    .funct3     (get_funct3(instr)),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .cond_true  (w_cond_true),
    .bad_funct3 (w_cond_bad)
  );

  // Jump wins outright; a non-branch never depends on instr, so X there cannot leak
  always_comb begin
    pc_src     = 1'b0;
    bad_funct3 = 1'b0;
    if (jump) begin
      pc_src     = 1'b1;
      bad_funct3 = 1'b0;
    end else if (branch) begin
      pc_src     = w_cond_true;
      bad_funct3 = w_cond_bad;
    end else begin
      pc_src     = 1'b0;
      bad_funct3 = 1'b0;
    end
  end

  // Status registers; err_sticky only clears through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_src_q   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_pc_src_q   <= pc_src;
      r_err_sticky <= r_err_sticky | bad_funct3;
    end
  end

  assign pc_src_q   = r_pc_src_q;
  assign err_sticky = r_err_sticky;

`ifdef PC_SRC_PERF_EN
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_branch_cnt;
  logic             w_br_exec;

  assign w_br_exec = branch & ~jump;

  // Free-running counters that wrap naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_taken_cnt  <= {CNT_W{1'b0}};
      r_branch_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_br_exec) begin
        r_branch_cnt <= r_branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_branch_cnt <= r_branch_cnt;
      end
      if (w_br_exec && pc_src) begin
        r_taken_cnt <= r_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_taken_cnt <= r_taken_cnt;
      end
    end
  end

  assign taken_cnt  = r_taken_cnt;
  assign branch_cnt = r_branch_cnt;
`endif

endmodule

// File: tb/tb_pc_src_unit.sv
// Self-checking bench for pc_src_unit: directed vector table, hand-written
// sticky/reset/counter sequences, and randomized operands against a reference model.
module tb_pc_src_unit;

  localparam int TB_CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch, jump, zero, lt, ltu;
  logic [31:0] instr;
  logic        pc_src, bad_funct3, pc_src_q, err_sticky;
`ifdef PC_SRC_PERF_EN
  logic [TB_CNT_W-1:0] taken_cnt, branch_cnt;
`endif

  int errs   = 0;
  int checks = 0;

  logic m_q;
  logic m_sticky;
  int   m_bcnt;
  int   m_tcnt;

  always #5 clk = ~clk;

  pc_src_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .instr      (instr),
    .pc_src     (pc_src),
    .bad_funct3 (bad_funct3),
    .pc_src_q   (pc_src_q),
`ifdef PC_SRC_PERF_EN
    .taken_cnt  (taken_cnt),
    .branch_cnt (branch_cnt),
`endif
    .err_sticky (err_sticky)
  );

  typedef struct {
    logic        b, j, z, l, lu;
    logic [31:0] ins;
    logic        exp_pc;
    logic        exp_bad;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Branch outcome computed from the actual operand values, not from flags
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic b, j, z, l, lu, input logic [31:0] ins);
    @(negedge clk);
    branch = b; jump = j; zero = z; lt = l; ltu = lu; instr = ins;
    #1;
  endtask

  task automatic check_regs();
    chk("pc_src_q", {31'd0, pc_src_q}, {31'd0, m_q});
    chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
`ifdef PC_SRC_PERF_EN
    chk("branch_cnt", {28'd0, branch_cnt}, 32'(m_bcnt % (1 << TB_CNT_W)));
    chk("taken_cnt", {28'd0, taken_cnt}, 32'(m_tcnt % (1 << TB_CNT_W)));
`endif
  endtask

  task automatic clock_check(input logic exp_pc, input logic exp_bad);
    m_q      = exp_pc;
    m_sticky = m_sticky | exp_bad;
    if (branch && !jump) begin
      m_bcnt++;
      if (exp_pc) m_tcnt++;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_q = 1'b0; m_sticky = 1'b0; m_bcnt = 0; m_tcnt = 0;
    check_regs();
    @(negedge clk);
    branch = 1'b0; jump = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] xins;
    rst_n = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    instr = 32'd0;
    m_q = 1'b0; m_sticky = 1'b0; m_bcnt = 0; m_tcnt = 0;

    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00628c63, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00628c63, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00629a63, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00629a63, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0062c863, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0062c863, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0062d663, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0062d663, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0052e863, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0052e863, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0062f263, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0062f263, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00628c63, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0062d663, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0062a063, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h008002ef, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h008002ef, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100302e7, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100302e7, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0062a063, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00628c63, 1'b1, 1'b0});

    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].b, vecs[i].j, vecs[i].z, vecs[i].l, vecs[i].lu, vecs[i].ins);
      chk($sformatf("pc_src[v%0d]", i), {31'd0, pc_src}, {31'd0, vecs[i].exp_pc});
      chk($sformatf("bad_funct3[v%0d]", i), {31'd0, bad_funct3}, {31'd0, vecs[i].exp_bad});
      clock_check(vecs[i].exp_pc, vecs[i].exp_bad);
    end

    // Non-branch with unknown instr must still select PC+4
    xins = 32'hxxxxxxxx;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, xins);
    chk("pc_src_xinstr", {31'd0, pc_src}, 32'd0);
    chk("bad_xinstr", {31'd0, bad_funct3}, 32'd0);
    clock_check(1'b0, 1'b0);

    // Illegal funct3 sets the sticky flag, which survives legal traffic
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0062a063);
    chk("pc_src_f3_010", {31'd0, pc_src}, 32'd0);
    chk("bad_f3_010", {31'd0, bad_funct3}, 32'd1);
    clock_check(1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0062b063);
    chk("bad_f3_011", {31'd0, bad_funct3}, 32'd1);
    clock_check(1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00628c63);
    clock_check(1'b1, 1'b0);
    chk("sticky_held", {31'd0, err_sticky}, 32'd1);

    // Reset clears status; combinational path stays live during reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("pc_src_in_reset", {31'd0, pc_src}, 32'd1);
    @(posedge clk);
    #1;
    chk("sticky_after_rst", {31'd0, err_sticky}, 32'd0);
    chk("q_after_rst", {31'd0, pc_src_q}, 32'd0);
    m_q = 1'b0; m_sticky = 1'b0; m_bcnt = 0; m_tcnt = 0;
    @(negedge clk);
    branch = 1'b0; jump = 1'b0;
    rst_n = 1'b1;

`ifdef PC_SRC_PERF_EN
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00628c63);
      clock_check(1'b1, 1'b0);
    end
    chk("branch_cnt_wrap", {28'd0, branch_cnt}, 32'd1);
    chk("taken_cnt_wrap", {28'd0, taken_cnt}, 32'd1);
    do_reset();
    chk("branch_cnt_rst", {28'd0, branch_cnt}, 32'd0);
    chk("taken_cnt_rst", {28'd0, taken_cnt}, 32'd0);
`endif

    // Random operands; flags derived from them, outcome from the operand compare
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b, ins;
      logic [2:0]  f3;
      logic        rb, rj, ep, eb;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {~a[31], b[30:0]};
      f3 = 3'($urandom_range(0, 7));
      ins = $urandom;
      ins[14:12] = f3;
      rb = 1'($urandom_range(0, 1));
      rj = ($urandom_range(0, 4) == 0);
      ep = rj ? 1'b1 : (rb ? ref_taken(f3, a, b) : 1'b0);
      eb = !rj && rb && (f3 == 3'd2 || f3 == 3'd3);
      drive(rb, rj, (a == b), ($signed(a) < $signed(b)), (a < b), ins);
      chk("rand_pc_src", {31'd0, pc_src}, {31'd0, ep});
      chk("rand_bad", {31'd0, bad_funct3}, {31'd0, eb});
      clock_check(ep, eb);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
